// File: rtl/spi_pkg.sv
// SPI slave receiver shared definitions.
// Provides the SPI mode encodings and helpers that turn a mode into its
// idle clock level and its sampling edge.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,   // CPOL 0, CPHA 0
        MODE1 = 2'd1,   // CPOL 0, CPHA 1
        MODE2 = 2'd2,   // CPOL 1, CPHA 0
        MODE3 = 2'd3    // CPOL 1, CPHA 1
    } spi_mode_e;

    // Modes 0 and 3 latch MOSI on the rising SCLK edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

    // Idle SCLK level.
    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/spi_slave_rx_fifo_if.sv
// Read-side bus of the SPI slave receiver FIFO.
//   data_rdy_out   : FIFO head valid
//   data_out       : FIFO head word
//   data_sof_out   : head word opened its CS frame
//   data_ack_in    : consumer pops the head
//   fifo_level_out : words currently stored
// slave modport = receiver side, master modport = consumer side.
interface spi_slave_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          data_rdy_out;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          data_sof_out;
    logic                          data_ack_in;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_out;

    modport slave (
        output data_rdy_out,
        output data_out,
        output data_sof_out,
        output fifo_level_out,
        input  data_ack_in
    );

    modport master (
        input  data_rdy_out,
        input  data_out,
        input  data_sof_out,
        input  fifo_level_out,
        output data_ack_in
    );
endinterface

// File: rtl/spi_slave_rx_fifo_fifo.sv
// Synchronous show-ahead FIFO.
//   clk_in, rst_in : clock and synchronous active-high reset
//   push_in        : write push_data_in (dropped when full unless popping too)
//   pop_in         : remove head (ignored when empty)
//   data_out       : head word; while empty it holds the last popped word
//   empty_out, full_out, level_out : occupancy
module sync_fifo_fwft
    import spi_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         push_data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty_out,
    output logic                     full_out,
    output logic [$clog2(DEPTH):0]   level_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign empty_out = (count == '0);
    assign full_out  = (count == LW'(DEPTH));
    assign do_pop    = pop_in && !empty_out;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push   = push_in && (!full_out || do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Once drained, the head slot is stale memory; show the last popped word instead.
    assign data_out  = empty_out ? hold_q : mem[rd_ptr];
    assign level_out = count;

endmodule

// File: rtl/spi_slave_rx_fifo.sv
// SPI slave receiver with show-ahead word FIFO, clocked only by clk_in.
// SCLK, MOSI and CS_N are oversampled through synchronisers.
//   clk_in, rst_in  : system clock (>= 4x SCLK), synchronous active-high reset
//   spi_sclk_in, spi_mosi_in, spi_cs_n_in : asynchronous SPI pins
//   rx_if           : FIFO read side (rdy/data/sof/ack/level)
//   overflow_out    : sticky, a word was dropped on a full FIFO
//   frame_end_out   : one-cycle pulse on CS deassert
//   partial_err_out : one-cycle pulse on CS deassert with an incomplete word
//
// state  | meaning
// IDLE   | CS deasserted, sampling edges ignored
// ACTIVE | CS asserted, assembling words
module spi_slave_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SPI_MODE    = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               spi_sclk_in,
    input  logic               spi_mosi_in,
    input  logic               spi_cs_n_in,
    spi_slave_rx_fifo_if.slave rx_if,
    output logic               overflow_out,
    output logic               frame_end_out,
    output logic               partial_err_out
);
    localparam logic           SAMPLE_RISE = sample_on_rise(2'(SPI_MODE));
    localparam logic           IDLE_SCLK   = cpol(2'(SPI_MODE));
    localparam int             CNT_W       = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s, mosi_s, cs_s;
    logic sample_edge, cs_fall, cs_rise;

    logic [0:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  sof_pending;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] assembled;
    logic                  push_vld;
    logic [DATA_WIDTH:0]   push_data;
    logic                  frame_end_q;
    logic                  partial_err_q;
    logic                  overflow_q;

    logic [DATA_WIDTH:0]   fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Reset loads idle levels so no edge is seen right after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= IDLE_SCLK;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign sample_edge = SAMPLE_RISE ? (sclk_s && !sclk_prev) : (!sclk_s && sclk_prev);
    assign cs_fall     = !cs_s && cs_prev;
    assign cs_rise     = cs_s && !cs_prev;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign assembled = {shift_reg[DATA_WIDTH-2:0], mosi_s};
        end else begin : g_lsb
            assign assembled = {mosi_s, shift_reg[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            sof_pending   <= 1'b0;
            shift_reg     <= '0;
            push_vld      <= 1'b0;
            push_data     <= '0;
            frame_end_q   <= 1'b0;
            partial_err_q <= 1'b0;
        end else begin
            push_vld      <= 1'b0;
            frame_end_q   <= 1'b0;
            partial_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state       <= ST_ACTIVE;
                        bit_cnt     <= '0;
                        sof_pending <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        // Incomplete bits are simply abandoned in shift_reg.
                        state         <= ST_IDLE;
                        frame_end_q   <= 1'b1;
                        partial_err_q <= (bit_cnt != '0);
                        bit_cnt       <= '0;
                    end else if (sample_edge && !cs_s) begin
                        shift_reg <= assembled;
                        if (bit_cnt == LAST_BIT) begin
                            push_vld    <= 1'b1;
                            push_data   <= {sof_pending, assembled};
                            bit_cnt     <= '0;
                            sof_pending <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // A push into a full FIFO survives only when the consumer pops that cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overflow_q <= 1'b0;
        end else if (push_vld && fifo_full && !rx_if.data_ack_in) begin
            overflow_q <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (push_vld),
        .push_data_in (push_data),
        .pop_in       (rx_if.data_ack_in),
        .data_out     (fifo_head),
        .empty_out    (fifo_empty),
        .full_out     (fifo_full),
        .level_out    (rx_if.fifo_level_out)
    );

    assign rx_if.data_rdy_out = !fifo_empty;
    assign rx_if.data_out     = fifo_head[DATA_WIDTH-1:0];
    assign rx_if.data_sof_out = fifo_head[DATA_WIDTH];

    assign overflow_out    = overflow_q;
    assign frame_end_out   = frame_end_q;
    assign partial_err_out = partial_err_q;

endmodule

// File: doc/spi_slave_rx_fifo.md
Name: spi_slave_rx_fifo

Overview:
Parametrised SPI slave receiver; successor to the single-byte SPI slave. Runs entirely in the system clock domain: SCLK, MOSI and CS_N are oversampled through synchronisers rather than clocking logic from SCLK. Supports all four SPI modes, configurable word width and bit order, and buffers received words in a show-ahead FIFO with a start-of-frame tag. Feeds the LED frame parser, which pops words with a valid/ack handshake.

Parameters:
DATA_WIDTH, 8, bits per SPI word (2..32).
FIFO_DEPTH, 16, buffered words; power of two, >= 2.
SPI_MODE, 0, {CPOL,CPHA} encoding 0..3.
MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_WIDTH-1]; 0 = it lands in data_out[0].
SYNC_STAGES, 2, synchroniser flops on each SPI input (>= 2).

Ports:
clk_in  input  1  system clock; must be >= 4x SCLK frequency.
rst_in  input  1  synchronous, active-high reset.
spi_sclk_in  input  1  SPI clock (asynchronous).
spi_mosi_in  input  1  SPI data (asynchronous).
spi_cs_n_in  input  1  chip select, active low (asynchronous).
data_rdy_out  output  1  FIFO head valid (FIFO not empty).
data_out  output  DATA_WIDTH  FIFO head word.
data_sof_out  output  1  head word is the first complete word of its CS frame.
data_ack_in  input  1  pop head; honoured only when data_rdy_out = 1.
fifo_level_out  output  $clog2(FIFO_DEPTH)+1  words currently stored.
overflow_out  output  1  sticky; a word was dropped because the FIFO was full.
frame_end_out  output  1  one-cycle pulse when CS deasserts.
partial_err_out  output  1  one-cycle pulse when CS deasserts with 1..DATA_WIDTH-1 bits pending.

Behaviour:
- Reset (rst_in high at a clk_in edge): FIFO empty; all outputs 0. Synchroniser and edge-detect flops load idle levels: sclk = CPOL, cs_n = 1, mosi = 0. No spurious edge follows reset.
- Sampling edge: rising SCLK for modes 0 and 3; falling SCLK for modes 1 and 2. Edges are detected on the synchronised SCLK (last stage vs. previous). MOSI is taken from its synchronised stage of equal depth.
- FSM: IDLE (cs_n sync = 1) to ACTIVE on synchronised cs_n falling. In ACTIVE, bit_cnt is cleared and sof_pending is set to 1.
- ACTIVE, on each sampling edge: shift MOSI into shift_reg (left for MSB_FIRST, right otherwise) and increment bit_cnt.
- When bit_cnt reaches DATA_WIDTH-1 and a sampling edge occurs: push {sof_pending, assembled word} into the FIFO on the next clk_in, clear bit_cnt, then clear sof_pending.
- Sampling edges while cs_n sync = 1 are ignored.
- ACTIVE to IDLE on synchronised cs_n rising: frame_end_out pulses for one cycle. If bit_cnt != 0, partial_err_out pulses in the same cycle and the partial bits are discarded (never pushed). bit_cnt is then cleared.
- Latency: last bit's SCLK edge at the pin to data_rdy_out = 1 is SYNC_STAGES + 2 clk_in cycles when the FIFO was empty.
- FIFO read side is show-ahead: data_out and data_sof_out are valid whenever data_rdy_out = 1. A pop occurs on data_ack_in && data_rdy_out, and the next entry appears the following cycle. data_ack_in while empty is ignored. When empty, data_out holds its last value.
- Full with push and pop in the same cycle: both occur; level unchanged; no overflow.
- Full with push and no pop: the word is dropped and overflow_out is set. overflow_out clears only on rst_in.
- Empty with push and pop in the same cycle: the pop is ignored and the push is stored.
- fifo_level_out is updated in the same cycle as pointers; range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- CS deassert and reassert within the sync window: each synchronised edge is handled in order. A new frame sets sof_pending again.

Decomposition:
- Package spi_pkg: SPI_MODE encodings (MODE0..MODE3), function sample_on_rise(mode) and function cpol(mode).
- Sub-module sync_fifo_fwft (WIDTH = DATA_WIDTH+1, DEPTH = FIFO_DEPTH): synchronous show-ahead FIFO with push, pop, full, empty and level outputs.
- Synchronisers, edge detect, FSM and shift register remain in the top module.

Test Plan:
- Mode 0, MSB_FIRST = 1, DATA_WIDTH = 8; one CS frame sending 0xA5, 0x3C -> two words 0xA5 (sof = 1) then 0x3C (sof = 0); one frame_end_out pulse; partial_err_out stays 0.
- Mode 3, MSB_FIRST = 0; send bits 1,0,0,0,0,0,0,0 -> data_out = 0x01. Repeat with modes 1 and 2 sending 0x81 -> 0x81 in all modes.
- Frame of 12 bits, with 0xF0 then 4 bits 1010 -> one word 0xF0; partial_err_out and frame_end_out pulse together; level = 1.
- FIFO_DEPTH = 4, data_ack_in held 0, 5 words sent -> level = 4, overflow_out = 1, and words 1..4 are read back in order. Then a push while full with data_ack_in = 1 in the same cycle -> level stays 4 and the new word is retained.
- Two back-to-back frames of 2 words each -> sof pattern 1,0,1,0. data_ack_in asserted while empty -> no level change.
- rst_in asserted mid-word (after 5 bits) -> all outputs 0 next cycle. With CPOL = 1 idle SCLK, no spurious word after reset release. The next full frame is received correctly.
